sm83_irq_ctrl: RTL and testbench

Interrupt controller at the far end of the SM83 core's `irq`/`iack` interface, and a memory-mapped responder on the CPU data bus. It latches rising edges of peripheral request lines into the interrupt-flag register IF and holds the enable register IE. It drives the masked pending vector to the core and clears IF bits when the core acknowledges. IF is mapped at 0xFF0F and IE at 0xFFFF; the bus decoder merges `dout` whenever `dout_oe` is high.

---
 rtl/sm83_pkg.sv | 33 +++
 rtl/sm83_irq_ctrl_if.sv | 28 ++
 rtl/sm83_edge_det.sv | 22 ++
 rtl/sm83_irq_ctrl.sv | 101 ++++++++++
 tb/tb_sm83_irq_ctrl.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/sm83_pkg.sv
// Shared definitions for the SM83 interrupt controller slice.
//   word_t          : 8-bit CPU data word
//   IF_ADR / IE_ADR : default register addresses
//   IRQ_*           : interrupt bit indices in IF/IE
//   IF_UNUSED_MASK  : IF read-back bits above the implemented sources (read as ones)
package sm83_pkg;

  typedef logic [7:0] word_t;

  localparam logic [15:0] IF_ADR = 16'hFF0F;
  localparam logic [15:0] IE_ADR = 16'hFFFF;

  localparam int unsigned IRQ_VBLANK = 0;
  localparam int unsigned IRQ_STAT   = 1;
  localparam int unsigned IRQ_TIMER  = 2;
  localparam int unsigned IRQ_SERIAL = 3;
  localparam int unsigned IRQ_JOYPAD = 4;

  localparam int unsigned NUM_SRC_DEFAULT = 5;

  // Ones in every bit position at or above num_src.
  function automatic word_t if_unused_mask(int unsigned num_src);
    word_t m;
    m = '0;
    for (int i = 0; i < 8; i++) begin
      if (i >= int'(num_src)) m[i] = 1'b1;
    end
    return m;
  endfunction

  localparam word_t IF_UNUSED_MASK = if_unused_mask(NUM_SRC_DEFAULT);

endpackage

// File: rtl/sm83_irq_ctrl_if.sv
// CPU-bus and interrupt-side signals of the interrupt controller.
//   master : CPU core / peripherals side (drives adr, din, strobes, req, iack)
//   slave  : controller side (drives dout, dout_oe, irq, wake)
interface sm83_irq_ctrl_if #(
  parameter int unsigned NUM_SRC   = 5,
  parameter int unsigned WORD_SIZE = 8
) ();
  logic [15:0]          adr;
  logic [WORD_SIZE-1:0] din;
  logic                 p_rd;
  logic                 p_wr;
  logic [WORD_SIZE-1:0] dout;
  logic                 dout_oe;
  logic [NUM_SRC-1:0]   req;
  logic [7:0]           irq;
  logic [7:0]           iack;
  logic                 wake;

  modport master (
    output adr, din, p_rd, p_wr, req, iack,
    input  dout, dout_oe, irq, wake
  );

  modport slave (
    input  adr, din, p_rd, p_wr, req, iack,
    output dout, dout_oe, irq, wake
  );
endinterface

// File: rtl/sm83_edge_det.sv
// Rising-edge detector, Width bits wide.
//   clk, reset : clock, synchronous active-high reset
//   d_i        : input vector
//   rise_o     : d_i & ~d_i(previous clk); history loads ResetVal on reset
module sm83_edge_det #(
  parameter int unsigned        Width    = 1,
  parameter logic [Width-1:0]   ResetVal = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] rise_o
);
  logic [Width-1:0] d_q;

  always_ff @(posedge clk) begin
    if (reset) d_q <= ResetVal;
    else       d_q <= d_i;
  end

  assign rise_o = d_i & ~d_q;
endmodule

// File: rtl/sm83_irq_ctrl.sv
// SM83 interrupt controller: IF/IE registers, request latching, ack clearing,
// and a registered memory-mapped read port.
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave modport (CPU bus adr/din/p_rd/p_wr/dout/dout_oe,
//                peripheral req, core irq/iack, wake)
module sm83_irq_ctrl import sm83_pkg::*; #(
  parameter int unsigned NUM_SRC   = 5,
  parameter int unsigned WORD_SIZE = 8,
  parameter logic [15:0] IF_ADR    = sm83_pkg::IF_ADR,
  parameter logic [15:0] IE_ADR    = sm83_pkg::IE_ADR
) (
  input logic             clk,
  input logic             reset,
  sm83_irq_ctrl_if.slave  bus
);
  localparam word_t UnusedMask = if_unused_mask(NUM_SRC);

  logic [NUM_SRC-1:0]   if_q, if_d;
  logic [WORD_SIZE-1:0] ie_q, ie_d;
  logic [WORD_SIZE-1:0] dout_q, dout_d;
  logic                 oe_q, oe_d;

  logic [NUM_SRC-1:0] req_set, ack_clr;
  logic               wr_rise, wr_if, wr_ie;

  // req history resets to ones so a line held high through reset does not fire.
  sm83_edge_det #(
    .Width   (NUM_SRC),
    .ResetVal({NUM_SRC{1'b1}})
  ) u_req_edge (
    .clk   (clk),
    .reset (reset),
    .d_i   (bus.req),
    .rise_o(req_set)
  );

  sm83_edge_det #(
    .Width   (NUM_SRC),
    .ResetVal('0)
  ) u_ack_edge (
    .clk   (clk),
    .reset (reset),
    .d_i   (bus.iack[NUM_SRC-1:0]),
    .rise_o(ack_clr)
  );

  // Write strobe history resets high: a strobe held through reset never commits.
  sm83_edge_det #(
    .Width   (1),
    .ResetVal(1'b1)
  ) u_wr_edge (
    .clk   (clk),
    .reset (reset),
    .d_i   (bus.p_wr),
    .rise_o(wr_rise)
  );

  assign wr_if = wr_rise && (bus.adr == IF_ADR);
  assign wr_ie = wr_rise && (bus.adr == IE_ADR);

  // Priority low to high: CPU write, ack clear, new request edge.
  always_comb begin
    if_d = wr_if ? bus.din[NUM_SRC-1:0] : if_q;
    if_d = (if_d & ~ack_clr) | req_set;
    ie_d = wr_ie ? bus.din : ie_q;
  end

  // Read data is built from the pre-edge register values.
  always_comb begin
    dout_d = '0;
    oe_d   = 1'b0;
    if (bus.p_rd) begin
      if (bus.adr == IF_ADR) begin
        oe_d   = 1'b1;
        dout_d = UnusedMask | word_t'(if_q);
      end else if (bus.adr == IE_ADR) begin
        oe_d   = 1'b1;
        dout_d = ie_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      if_q   <= '0;
      ie_q   <= '0;
      dout_q <= '0;
      oe_q   <= 1'b0;
    end else begin
      if_q   <= if_d;
      ie_q   <= ie_d;
      dout_q <= dout_d;
      oe_q   <= oe_d;
    end
  end

  assign bus.dout    = dout_q;
  assign bus.dout_oe = oe_q;
  assign bus.irq     = word_t'(if_q & ie_q[NUM_SRC-1:0]);
  assign bus.wake    = |bus.irq;
endmodule

// File: tb/tb_sm83_irq_ctrl.sv
module tb_sm83_irq_ctrl;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  sm83_irq_ctrl_if #(.NUM_SRC(5), .WORD_SIZE(8)) bus ();

  sm83_irq_ctrl #(
    .NUM_SRC  (5),
    .WORD_SIZE(8),
    .IF_ADR   (16'hFF0F),
    .IE_ADR   (16'hFFFF)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [15:0] adr;
    logic [7:0]  din;
    logic [4:0]  req;
    logic [7:0]  iack;
    logic [7:0]  exp_irq;
    logic        exp_oe;
    logic [7:0]  exp_dout;
  } vec_t;

  vec_t vecs[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string name, input logic [7:0] irq, input logic oe,
                            input logic [7:0] dout);
    check({name, ".irq"}, bus.irq, irq);
    check({name, ".wake"}, {7'd0, bus.wake}, {7'd0, irq != 8'h00});
    check({name, ".oe"}, {7'd0, bus.dout_oe}, {7'd0, oe});
    check({name, ".dout"}, bus.dout, dout);
  endtask

  task automatic add(input string name, input logic rd, input logic wr, input logic [15:0] adr,
                     input logic [7:0] din, input logic [4:0] req, input logic [7:0] iack,
                     input logic [7:0] exp_irq, input logic exp_oe, input logic [7:0] exp_dout);
    vec_t v;
    v.name = name; v.rd = rd; v.wr = wr; v.adr = adr; v.din = din; v.req = req; v.iack = iack;
    v.exp_irq = exp_irq; v.exp_oe = exp_oe; v.exp_dout = exp_dout;
    vecs.push_back(v);
  endtask

  initial begin
    // name            rd  wr  adr       din    req       iack   irq    oe  dout
    add("hold_req",    1, 0, 16'hFF0F, 8'h00, 5'b00001, 8'h00, 8'h00, 1, 8'hE0);
    add("drop_req",    1, 0, 16'hFF0F, 8'h00, 5'b00000, 8'h00, 8'h00, 1, 8'hE0);
    add("rise_req0",   0, 0, 16'h0000, 8'h00, 5'b00001, 8'h00, 8'h00, 0, 8'h00);
    add("rd_if_e1",    1, 0, 16'hFF0F, 8'h00, 5'b00001, 8'h00, 8'h00, 1, 8'hE1);
    add("clr_if",      0, 1, 16'hFF0F, 8'h00, 5'b00001, 8'h00, 8'h00, 0, 8'h00);
    add("idle",        0, 0, 16'h0000, 8'h00, 5'b00000, 8'h00, 8'h00, 0, 8'h00);
    add("wr_ie05",     0, 1, 16'hFFFF, 8'h05, 5'b00000, 8'h00, 8'h00, 0, 8'h00);
    add("rd_ie05",     1, 0, 16'hFFFF, 8'h00, 5'b00000, 8'h00, 8'h00, 1, 8'h05);
    add("req2",        0, 0, 16'h0000, 8'h00, 5'b00100, 8'h00, 8'h04, 0, 8'h00);
    add("rd_if_e4",    1, 0, 16'hFF0F, 8'h00, 5'b00000, 8'h00, 8'h04, 1, 8'hE4);
    add("req1_masked", 0, 0, 16'h0000, 8'h00, 5'b00010, 8'h00, 8'h04, 0, 8'h00);
    add("rd_if_e6",    1, 0, 16'hFF0F, 8'h00, 5'b00000, 8'h00, 8'h04, 1, 8'hE6);
    add("ack2",        0, 0, 16'h0000, 8'h00, 5'b00000, 8'h04, 8'h00, 0, 8'h00);
    add("rd_if_e2",    1, 0, 16'hFF0F, 8'h00, 5'b00000, 8'h04, 8'h00, 1, 8'hE2);
    add("req2_ackhld", 0, 0, 16'h0000, 8'h00, 5'b00100, 8'h04, 8'h04, 0, 8'h00);
    add("rd_ackhld",   1, 0, 16'hFF0F, 8'h00, 5'b00100, 8'h04, 8'h04, 1, 8'hE6);
    add("release",     0, 0, 16'h0000, 8'h00, 5'b00000, 8'h00, 8'h04, 0, 8'h00);
    add("req3",        0, 0, 16'h0000, 8'h00, 5'b01000, 8'h00, 8'h04, 0, 8'h00);
    add("drop3",       0, 0, 16'h0000, 8'h00, 5'b00000, 8'h00, 8'h04, 0, 8'h00);
    add("req_ack3",    0, 0, 16'h0000, 8'h00, 5'b01000, 8'h08, 8'h04, 0, 8'h00);
    add("rd_if_ee",    1, 0, 16'hFF0F, 8'h00, 5'b00000, 8'h00, 8'h04, 1, 8'hEE);
    add("wr_if_req0",  0, 1, 16'hFF0F, 8'h00, 5'b00001, 8'h00, 8'h01, 0, 8'h00);
    add("rd_if_e1b",   1, 0, 16'hFF0F, 8'h00, 5'b00001, 8'h00, 8'h01, 1, 8'hE1);
    add("ack_multi",   0, 0, 16'h0000, 8'h00, 5'b00001, 8'h93, 8'h00, 0, 8'h00);
    add("rd_if_e0",    1, 0, 16'hFF0F, 8'h00, 5'b00001, 8'h00, 8'h00, 1, 8'hE0);

    // Reset with req[0] held high.
    reset = 1'b1;
    bus.adr = 16'h0000; bus.din = 8'h00; bus.p_rd = 1'b0; bus.p_wr = 1'b0;
    bus.req = 5'b00001; bus.iack = 8'h00;
    repeat (3) tick();
    check_outs("reset", 8'h00, 1'b0, 8'h00);
    reset = 1'b0;

    foreach (vecs[i]) begin
      bus.p_rd = vecs[i].rd;
      bus.p_wr = vecs[i].wr;
      bus.adr  = vecs[i].adr;
      bus.din  = vecs[i].din;
      bus.req  = vecs[i].req;
      bus.iack = vecs[i].iack;
      tick();
      check_outs(vecs[i].name, vecs[i].exp_irq, vecs[i].exp_oe, vecs[i].exp_dout);
    end
    bus.p_rd = 1'b0; bus.p_wr = 1'b0; bus.iack = 8'h00;

    // Held write strobe commits once; read in the commit clk sees the old IE.
    bus.adr = 16'hFFFF; bus.din = 8'h1F; bus.p_wr = 1'b1; bus.p_rd = 1'b1;
    tick();
    check("held_wr.commit_clk_old", bus.dout, 8'h05);
    tick();
    check("held_wr.new_value", bus.dout, 8'h1F);
    repeat (2) tick();
    bus.din = 8'h00;
    repeat (2) tick();
    bus.p_wr = 1'b0;
    tick();
    check("held_wr.single_commit", bus.dout, 8'h1F);
    check("held_wr.oe", {7'd0, bus.dout_oe}, 8'h01);
    bus.p_rd = 1'b0;
    tick();
    check_outs("rd_drop", 8'h00, 1'b0, 8'h00);

    // Unmapped address.
    bus.p_rd = 1'b1; bus.adr = 16'hFF10;
    tick();
    check_outs("rd_unmapped", 8'h00, 1'b0, 8'h00);
    bus.p_rd = 1'b0;

    // Load IF=1F, IE=1F, then reset mid-operation with new edges pending.
    bus.adr = 16'hFF0F; bus.din = 8'h1F; bus.p_wr = 1'b1;
    tick();
    bus.p_wr = 1'b0;
    tick();
    bus.adr = 16'hFFFF; bus.p_wr = 1'b1;
    tick();
    bus.p_wr = 1'b0;
    tick();
    check_outs("pre_reset", 8'h1F, 1'b0, 8'h00);

    reset = 1'b1; bus.req = 5'b11111; bus.p_wr = 1'b1; bus.adr = 16'hFF0F; bus.din = 8'h1F;
    bus.p_rd = 1'b1;
    tick();
    check_outs("mid_reset", 8'h00, 1'b0, 8'h00);
    reset = 1'b0; bus.p_wr = 1'b0; bus.adr = 16'hFFFF;
    tick();
    check_outs("post_reset_ie", 8'h00, 1'b1, 8'h00);
    bus.adr = 16'hFF0F;
    tick();
    check_outs("post_reset_if", 8'h00, 1'b1, 8'hE0);
    bus.p_rd = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
